// File: rtl/tgl_hs_pkg.sv
// Shared defaults and helpers for the toggle-handshake receiver.
package tgl_hs_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 4;

  // Ack level driven out of reset; the sender must start from the same level.
  localparam logic ACK_RESET = 1'b0;

  // Occupancy counter width: one extra bit so that count can hold DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full occupancy count; accepts a write while full
// provided a read happens in the same cycle.
module sync_fifo
  import tgl_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr];

  // Storage array: written at the tail, no reset needed for data.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap modulo DEPTH; count tracks the net push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tgl_hs_rx.sv
// Receiver for the toggle-signalling handshake: every req_tgl level change
// captures data_in into a FIFO and is answered by flipping ack_tgl.
module tgl_hs_rx
  import tgl_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  count,
  output logic              proto_err
);

  logic req_q;
  logic pending;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic err_now;

  // A request is outstanding whenever the two toggle levels disagree.
  always_comb begin
    pending    = (req_tgl != ack_tgl);
    dout_valid = ~empty;
    pop        = dout_valid & dout_ready;
    push       = pending & (~full | pop);
    err_now    = (req_q != ack_tgl) & (req_tgl != req_q);
  end

  // Ack flips on capture; req_q remembers last req level for error detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_tgl   <= ACK_RESET;
      req_q     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      req_q <= req_tgl;
      if (push)    ack_tgl   <= ~ack_tgl;
      if (err_now) proto_err <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (dout),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_tgl_hs_rx.sv
// Directed self-checking bench for tgl_hs_rx (DATA_W=8, DEPTH=4).
module tb_tgl_hs_rx;

  logic       clk;
  logic       reset;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       ack_tgl;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] count;
  logic       proto_err;

  int errors = 0;
  int checks = 0;

  tgl_hs_rx #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_tgl    (req_tgl),
    .data_in    (data_in),
    .ack_tgl    (ack_tgl),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] d;
    logic       rdy;
    logic       ack;
    logic [2:0] cnt;
    logic       vld;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int rst, input int req, input int d, input int rdy,
                             input int ack, input int cnt, input int vld, input int dq,
                             input int err);
    vec_t r;
    r.rst  = rst[0];
    r.req  = req[0];
    r.d    = d[7:0];
    r.rdy  = rdy[0];
    r.ack  = ack[0];
    r.cnt  = cnt[2:0];
    r.vld  = vld[0];
    r.dout = dq[7:0];
    r.err  = err[0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_tgl    = 1'b0;
    data_in    = 8'h00;
    dout_ready = 1'b0;

    // rst req data rdy | ack cnt vld dout err
    tbl.push_back(v(1, 0, 'h00, 0,  0, 0, 0, 'h00, 0));
    tbl.push_back(v(0, 1, 'hA5, 0,  1, 1, 1, 'hA5, 0));
    tbl.push_back(v(0, 1, 'hA5, 1,  1, 0, 0, 'h00, 0));
    tbl.push_back(v(0, 0, 'h11, 0,  0, 1, 1, 'h11, 0));
    tbl.push_back(v(0, 1, 'h22, 0,  1, 2, 1, 'h11, 0));
    tbl.push_back(v(0, 0, 'h33, 0,  0, 3, 1, 'h11, 0));
    tbl.push_back(v(0, 1, 'h44, 0,  1, 4, 1, 'h11, 0));
    tbl.push_back(v(0, 0, 'h55, 0,  1, 4, 1, 'h11, 0));
    tbl.push_back(v(0, 0, 'h55, 0,  1, 4, 1, 'h11, 0));
    tbl.push_back(v(0, 0, 'h55, 0,  1, 4, 1, 'h11, 0));
    tbl.push_back(v(0, 0, 'h55, 1,  0, 4, 1, 'h22, 0));
    tbl.push_back(v(0, 0, 'h55, 1,  0, 3, 1, 'h33, 0));
    tbl.push_back(v(0, 0, 'h55, 1,  0, 2, 1, 'h44, 0));
    tbl.push_back(v(0, 0, 'h55, 1,  0, 1, 1, 'h55, 0));
    tbl.push_back(v(0, 0, 'h55, 1,  0, 0, 0, 'h00, 0));

    // Reset, single word, fill and backpressure, pop+push on a full FIFO.
    foreach (tbl[i]) begin
      reset      = tbl[i].rst;
      req_tgl    = tbl[i].req;
      data_in    = tbl[i].d;
      dout_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d ack", i), int'(ack_tgl), int'(tbl[i].ack));
      chk($sformatf("vec%0d count", i), int'(count), int'(tbl[i].cnt));
      chk($sformatf("vec%0d valid", i), int'(dout_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d err", i), int'(proto_err), int'(tbl[i].err));
      if (tbl[i].vld)
        chk($sformatf("vec%0d dout", i), int'(dout), int'(tbl[i].dout));
    end

    // Streaming with the consumer always ready: pointers wrap, order kept.
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_tgl = ~req_tgl;
      data_in = 8'(i);
      step();
      chk($sformatf("stream%0d ack", i), int'(ack_tgl), int'(req_tgl));
      chk($sformatf("stream%0d count", i), int'(count), 1);
      chk($sformatf("stream%0d dout", i), int'(dout), i);
    end
    step();
    chk("stream drained", int'(count), 0);

    // Double toggle while full raises a sticky error; reset clears it.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_tgl = ~req_tgl;
      data_in = 8'(8'hC0 + i);
      step();
      chk($sformatf("fill%0d count", i), int'(count), i + 1);
    end
    req_tgl = ~req_tgl;
    step();
    chk("err first toggle ack", int'(ack_tgl), 0);
    chk("err first toggle flag", int'(proto_err), 0);
    req_tgl = ~req_tgl;
    step();
    chk("err second toggle flag", int'(proto_err), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("err sticky%0d", i), int'(proto_err), 1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err reset flag", int'(proto_err), 0);
    chk("err reset count", int'(count), 0);
    chk("err reset ack", int'(ack_tgl), 0);

    // Reset mid-operation discards words; a held request is taken afresh.
    for (int i = 0; i < 3; i++) begin
      req_tgl = ~req_tgl;
      data_in = 8'(8'hE0 + i);
      step();
    end
    chk("load3 count", int'(count), 3);
    chk("load3 ack", int'(ack_tgl), 1);
    reset      = 1'b1;
    dout_ready = 1'b1;
    step();
    chk("midrst valid", int'(dout_valid), 0);
    chk("midrst count", int'(count), 0);
    chk("midrst ack", int'(ack_tgl), 0);
    reset      = 1'b0;
    dout_ready = 1'b0;
    data_in    = 8'h77;
    step();
    chk("fresh ack", int'(ack_tgl), 1);
    chk("fresh count", int'(count), 1);
    chk("fresh dout", int'(dout), 'h77);
    step();
    chk("fresh single count", int'(count), 1);

    // Idle handshake: random consumer readiness must not create words.
    dout_ready = 1'b1;
    step();
    chk("idle drain count", int'(count), 0);
    for (int i = 0; i < 20; i++) begin
      dout_ready = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("idle%0d count", i), int'(count), 0);
      chk($sformatf("idle%0d ack", i), int'(ack_tgl), 1);
      chk($sformatf("idle%0d valid", i), int'(dout_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
